uart_rx_os: RTL and testbench

Parametrised 16x-oversampling UART receiver, the successor to the fixed 8N1 receive path. Data width, parity mode, stop-bit count and baud divider are selectable at runtime. Each received word is returned over a valid/ready interface with parity, framing and overrun status. It sits between the board RX pin and the debug/console bridge logic; the default configuration is 38400 baud at 100 MHz.

---
 rtl/uart_cfg_pkg.sv | 19 +
 rtl/uart_rx_os_if.sv | 21 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_os.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the 16x-oversampling UART receive path
// (and its future transmit sibling).
package uart_cfg_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_e;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

    localparam int UART_OS_RATE     = 16;
    localparam int UART_MID_SAMPLE  = 7;
    localparam int DIV_38400_100MHZ = 163;
    localparam int DIV_38400_50MHZ  = 81;

    // Requested frame length, falling back to the maximum when out of range.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] req, input int max_bits);
        return (req < 4'd5 || int'(req) > max_bits) ? 4'(max_bits) : req;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word valid/ready channel: master is the receiver, slave the consumer.
interface uart_rx_os_if #(
    parameter int DATA_W = 9
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;

    modport master (
        output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Runtime-programmable divider producing the 16x oversample tick.
// A divider of 0 stops the ticks and parks the counter at 0.
module uart_baud_tick
    import uart_cfg_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             os_tick
);
    logic [DIV_W-1:0] cnt_reg;
    logic             at_top;

    assign at_top  = (cnt_reg == div - DIV_W'(1));
    assign os_tick = (div != '0) && at_top;

    // ">=" recovers cleanly if the divider is lowered below the current count.
    always_ff @(posedge clk) begin
        if (!rst_n || div == '0) begin
            cnt_reg <= '0;
        end else if (cnt_reg >= div - DIV_W'(1)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with runtime frame format and valid/ready output.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote of samples 6, 7 and 8.
module uart_rx_os
    import uart_cfg_pkg::*;
#(
    parameter int DATA_W      = 9,
    parameter int DIV_W       = 8,
    parameter int DIV_DEF     = DIV_38400_100MHZ,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [3:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic             rx_busy,
    uart_rx_os_if.master     rx
);
    if (SYNC_STAGES < 2 || DIV_DEF >= (2 ** DIV_W) || DATA_W > 15) begin : g_bad_cfg
        $error("uart_rx_os: unsupported parameter combination");
    end

    logic os_tick;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (cfg_div),
        .os_tick (os_tick)
    );

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxd_s;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_reg <= '1;
        else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd};
    end
    assign rxd_s = sync_reg[SYNC_STAGES-1];

    logic       bit_val;
    logic [3:0] os_cnt_reg, os_cnt_next;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_CNT = 4'(UART_MID_SAMPLE + 1);
    logic [1:0] maj_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            maj_reg <= 2'b11;
        end else if (os_tick && os_cnt_reg == 4'(UART_MID_SAMPLE - 1)) begin
            maj_reg[0] <= rxd_s;
        end else if (os_tick && os_cnt_reg == 4'(UART_MID_SAMPLE)) begin
            maj_reg[1] <= rxd_s;
        end
    end
    assign bit_val = (maj_reg[0] & maj_reg[1]) | (maj_reg[0] & rxd_s) | (maj_reg[1] & rxd_s);
`else
    localparam logic [3:0] SAMPLE_CNT = 4'(UART_MID_SAMPLE);
    assign bit_val = rxd_s;
`endif

    rx_state_e         state_reg, state_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [3:0]        nbits_reg, nbits_next;
    parity_e           par_reg, par_next;
    logic              stop2_reg, stop2_next;
    logic              stop_idx_reg, stop_idx_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              par_acc_reg, par_acc_next;
    logic              perr_reg, perr_next;
    logic              ferr_reg, ferr_next;
    logic              done_reg, done_next;
    logic              mid, end_bit;

    assign mid     = os_tick && (os_cnt_reg == SAMPLE_CNT);
    assign end_bit = os_tick && (os_cnt_reg == 4'(UART_OS_RATE - 1));

    always_comb begin
        state_next    = state_reg;
        os_cnt_next   = os_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        nbits_next    = nbits_reg;
        par_next      = par_reg;
        stop2_next    = stop2_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        par_acc_next  = par_acc_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        done_next     = 1'b0;

        if (os_tick) begin
            os_cnt_next = (state_reg == ST_IDLE) ? 4'd0 : os_cnt_reg + 4'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (os_tick && !rxd_s) begin
                    state_next    = ST_START;
                    os_cnt_next   = '0;
                    nbits_next    = eff_data_bits(cfg_data_bits, DATA_W);
                    par_next      = parity_e'(cfg_parity);
                    stop2_next    = cfg_stop2;
                    stop_idx_next = 1'b0;
                    bit_cnt_next  = '0;
                    shift_next    = '0;
                    par_acc_next  = 1'b0;
                    perr_next     = 1'b0;
                    ferr_next     = 1'b0;
                end
            end
            ST_START: begin
                if (mid && bit_val) state_next = ST_IDLE;
                else if (end_bit)   state_next = ST_DATA;
            end
            ST_DATA: begin
                if (mid) begin
                    shift_next[bit_cnt_reg] = bit_val;
                    par_acc_next            = par_acc_reg ^ bit_val;
                    bit_cnt_next            = bit_cnt_reg + 4'd1;
                end
                // bit_cnt has already advanced at mid-bit, so it equals nbits at the last bit's end.
                if (end_bit && bit_cnt_reg == nbits_reg) begin
                    state_next = (par_reg == PAR_EVEN || par_reg == PAR_ODD) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (mid && (bit_val != (par_acc_reg ^ (par_reg == PAR_ODD)))) perr_next = 1'b1;
                if (end_bit) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (mid) begin
                    if (!bit_val) ferr_next = 1'b1;
                    if (!stop2_reg || stop_idx_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
                if (end_bit) stop_idx_next = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        if (cfg_div == '0) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            nbits_reg    <= 4'(DATA_W);
            par_reg      <= PAR_NONE;
            stop2_reg    <= 1'b0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            par_acc_reg  <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            os_cnt_reg   <= os_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            nbits_reg    <= nbits_next;
            par_reg      <= par_next;
            stop2_reg    <= stop2_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            par_acc_reg  <= par_acc_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            done_reg     <= done_next;
        end
    end

    assign rx_busy = (state_reg != ST_IDLE);

    // A finished word lands only if the holding register is empty or being drained now.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx.rx_data       <= '0;
            rx.rx_parity_err <= 1'b0;
            rx.rx_frame_err  <= 1'b0;
            rx.rx_valid      <= 1'b0;
            rx.rx_overrun    <= 1'b0;
        end else begin
            rx.rx_overrun <= 1'b0;
            if (done_reg) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_data       <= shift_reg;
                    rx.rx_parity_err <= perr_reg;
                    rx.rx_frame_err  <= ferr_reg;
                    rx.rx_valid      <= 1'b1;
                end else begin
                    rx.rx_overrun <= 1'b1;
                end
            end else if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: stimulus queues expected words, a monitor
// checks each word as it is accepted over the valid/ready channel.
module tb_uart_rx_os;
    import uart_cfg_pkg::*;

    localparam int DATA_W = 9;
    localparam int BIT_CLK = 48;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] cfg_div = 8'd3;
    logic [3:0] cfg_data_bits = 4'd8;
    logic [1:0] cfg_parity = 2'd0;
    logic       cfg_stop2 = 1'b0;
    logic       rx_busy;

    uart_rx_os_if #(.DATA_W(DATA_W)) rx_if ();

    uart_rx_os #(
        .DATA_W      (DATA_W),
        .DIV_W       (8),
        .DIV_DEF     (DIV_38400_100MHZ),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rx_busy       (rx_busy),
        .rx            (rx_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic              ferr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ovr_cnt = 0;
    int   saw_busy = 0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Monitor: compares every word at the moment the consumer accepts it.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rx_if.rx_overrun) ovr_cnt++;
        if (rst_n && rx_busy) saw_busy = 1;
        if (rst_n && rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("word data=0x%03h perr=%0b ferr=%0b (req 0x%03h %0b %0b)",
                         rx_if.rx_data, rx_if.rx_parity_err, rx_if.rx_frame_err, e.data, e.perr, e.ferr);
                check("rx_data", int'(rx_if.rx_data), int'(e.data));
                check("rx_parity_err", int'(rx_if.rx_parity_err), int'(e.perr));
                check("rx_frame_err", int'(rx_if.rx_frame_err), int'(e.ferr));
            end
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 rxd = b;
        repeat (BIT_CLK - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit par_en,
                              input bit par_bit, input int nstop, input bit last_stop);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        for (int i = 0; i < nstop; i++) send_bit((i == nstop - 1) ? last_stop : 1'b1);
        @(posedge clk);
        #1 rxd = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, int'(rx_if.rx_valid), 0);
        check({tag, "_data"}, int'(rx_if.rx_data), 0);
        check({tag, "_perr"}, int'(rx_if.rx_parity_err), 0);
        check({tag, "_ferr"}, int'(rx_if.rx_frame_err), 0);
        check({tag, "_overrun"}, int'(rx_if.rx_overrun), 0);
        check({tag, "_busy"}, int'(rx_busy), 0);
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        check_cleared("reset");

        // 8N1
        exp_q.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b0});
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(2);

        // 7E1, correct then wrong parity bit
        cfg_data_bits = 4'd7;
        cfg_parity    = 2'd1;
        exp_q.push_back('{data: 9'h035, perr: 1'b0, ferr: 1'b0});
        send_frame(9'h035, 7, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        exp_q.push_back('{data: 9'h035, perr: 1'b1, ferr: 1'b0});
        send_frame(9'h035, 7, 1'b1, 1'b1, 1, 1'b1);
        idle_bits(2);

        // 8N2 with the second stop bit low; trailing low half-bit must only false-start
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'd0;
        cfg_stop2     = 1'b1;
        exp_q.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b1});
        send_frame(9'h03C, 8, 1'b0, 1'b0, 2, 1'b0);
        idle_bits(3);
        check("stop2_busy_idle", int'(rx_busy), 0);

        // Overrun: consumer stalled across two back-to-back words
        cfg_stop2      = 1'b0;
        rx_if.rx_ready = 1'b0;
        exp_q.push_back('{data: 9'h011, perr: 1'b0, ferr: 1'b0});
        send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(1);
        check("held_valid", int'(rx_if.rx_valid), 1);
        check("held_data", int'(rx_if.rx_data), 'h011);
        check("overrun_pulses", ovr_cnt, 1);
        rx_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("valid_drop", int'(rx_if.rx_valid), 0);

        // False start: 4-clk glitch
        idle_bits(1);
        saw_busy = 0;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check("false_start_busy_seen", saw_busy, 1);
        check("false_start_busy_idle", int'(rx_busy), 0);

        // Reset in the middle of DATA, then a clean frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(posedge clk);
        #1 rxd = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_cleared("midreset");
        idle_bits(2);
        exp_q.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b0});
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(2);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
